matrix_mult_sequencer: RTL and testbench
========================================

Name: matrix_mult_sequencer

Overview:
Parametrised control sequencer for the FP32 matrix-multiply engine; generalises the fixed 4x4 flow to runtime dimensions up to MAX_DIM x MAX_DIM.
Walks i/j/k over operand memory, fetches A(i,k) and B(k,j) through one read port, and streams the pairs to an external FP multiply-accumulate unit over a valid/ready handshake.
Writes each C(i,j) back to memory.
Sits between the memory-mapped status/config registers (status word addr 0, start = bit 31; config word addr 1) and the shared operand RAM.

Parameters:
DATA_W, 32, operand/result word width (IEEE-754 single)
ADDR_W, 12, memory address width
DIM_W, 8, width of each packed dimension field in the config word
MAX_DIM, 32, largest legal dimension (A, B, C regions must each fit MAX_DIM^2 words)
A_BASE, 2, address of A(0,0); row-major
B_BASE, 1026, address of B(0,0); row-major
C_BASE, 2050, address of C(0,0); row-major

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; sampled only in IDLE/DONE
cfg  in  4*DIM_W  {rowsA, colsA, rowsB, colsB}, MSB first (0x04040404 = 4x4 by 4x4)
mem_rd_en  out  1  read strobe
mem_rd_addr  out  ADDR_W  read address
mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
mem_wr_en  out  1  write strobe, single cycle
mem_wr_addr  out  ADDR_W  write address
mem_wr_data  out  DATA_W  write data
mac_valid  out  1  operand pair valid
mac_ready  in  1  MAC accepts pair when mac_valid && mac_ready
mac_a, mac_b  out  DATA_W  operands
mac_first  out  1  pair is k==0; MAC clears its accumulator
mac_last  out  1  pair is k==colsA-1
mac_res_valid  in  1  one-cycle pulse with the final sum
mac_res  in  DATA_W  accumulated result
busy  out  1  high from CHECK until DONE/ERR entered
done  out  1  sticky; cleared by next accepted start
error  out  1  sticky config error; cleared by next accepted start

Behaviour:
- Reset: every output 0; state IDLE; counters 0. Reset mid-run aborts immediately; no partial write is issued after reset asserts.
- IDLE/DONE/ERR + start: latch cfg into M, K, K2, N; clear done/error; go to CHECK. start in any other state is ignored.
- CHECK (1 cycle): go to ERR if K != K2, any field == 0, or any field > MAX_DIM; otherwise zero i, j, k and go to RD_A.
- RD_A: mem_rd_en=1, addr = A_BASE + i*K + k; go to RD_B.
- RD_B: mem_rd_en=1, addr = B_BASE + k*N + j; a_reg <= mem_rd_data; go to CAP.
- CAP: b_reg <= mem_rd_data; go to ISSUE.
- ISSUE: mac_valid=1 with mac_a=a_reg, mac_b=b_reg, mac_first=(k==0), mac_last=(k==K-1).
  - Hold all MAC outputs stable until the handshake completes.
  - On handshake: if k==K-1, go to WAIT_RES; else k++ and go to RD_A.
- WAIT_RES: wait for mac_res_valid, latch mac_res, go to WRITE. A mac_res_valid pulse in any other state is ignored.
- WRITE: mem_wr_en=1 for one cycle, addr = C_BASE + i*N + j; k <= 0.
  - j==N-1 and i==M-1: go to DONE.
  - j==N-1 otherwise: j <= 0, i++.
  - else j++. Then go to RD_A.
- DONE: done=1, busy=0. ERR: error=1, done=1, busy=0. No memory or MAC activity.
- Address arithmetic: no multipliers. Keep incremental row-base registers (a_row += K on i++; b_row += N on k++; c_row += N on i++). Addresses are truncated to ADDR_W.
- Minimum throughput: 4 cycles per k when mac_ready=1, plus WAIT_RES latency and 1 write cycle per element.
- mem_rd_en and mem_wr_en are never high in the same cycle.

Decomposition:
- Package mm_pkg holds:
  - cfg field offsets and the DIM_W default;
  - state enum {IDLE, CHECK, RD_A, RD_B, CAP, ISSUE, WAIT_RES, WRITE, DONE, ERR};
  - the default A/B/C base constants;
  - the status start-bit index (31).
- One sub-module, mm_addr_gen: i/j/k counters, incremental row-base registers, last-flags, and the three address outputs. The FSM drives its step/clear controls.

Test Plan:
- 1x1 (cfg 0x01010101), A=1.0, B=64.358, MAC model returns the product -> one pair with first=last=1; single write to 2050 with the product; done=1, error=0.
- 2x3 by 3x2 (cfg 0x02030302) -> read order A2,B1026,A3,B1028,A4,B1030; C writes to 2050,2051,2052,2053 in that order; 12 MAC handshakes.
- 4x4 (cfg 0x04040404) with the team matrices, reference MAC model -> 16 C words match the golden FP32 products within 1 ulp of the model.
- cfg 0x04040304 or 0x21040404 (33 > MAX_DIM) -> ERR within 2 cycles of start; error=done=1; no mem_rd_en/mem_wr_en ever asserted.
- mac_ready low for 5 cycles in ISSUE -> mac_a/mac_b/mac_first/mac_last stable throughout; exactly one accept; results unchanged.
- start pulsed mid-run -> ignored. reset asserted during WAIT_RES -> all outputs 0 in the same cycle; no write; a fresh start runs cleanly.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply sequencer: config layout, default
// memory map and the FSM state encoding.
package mm_pkg;

   localparam int DEF_DIM_W = 8;

   // Field index within cfg; bit offset is index * DIM_W, rowsA in the top field
   localparam int CFG_ROWS_A = 3;
   localparam int CFG_COLS_A = 2;
   localparam int CFG_ROWS_B = 1;
   localparam int CFG_COLS_B = 0;

   localparam int DEF_A_BASE = 2;
   localparam int DEF_B_BASE = 1026;
   localparam int DEF_C_BASE = 2050;

   localparam int STATUS_START_BIT = 31;

   typedef enum logic [3:0] {
      IDLE, CHECK, RD_A, RD_B, CAP, ISSUE, WAIT_RES, WRITE, DONE, ERR
   } mm_state_e;

endpackage

// File: rtl/mm_addr_gen.sv
// i/j/k loop counters with incremental row bases; produces the A, B and C
// word addresses without any multiplier.
module mm_addr_gen #(
   parameter int ADDR_W = 12,
   parameter int DIM_W  = 8,
   parameter int A_BASE = 2,
   parameter int B_BASE = 1026,
   parameter int C_BASE = 2050
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DIM_W-1:0]  dim_m,
   input  logic [DIM_W-1:0]  dim_k,
   input  logic [DIM_W-1:0]  dim_n,
   input  logic              clear,
   input  logic              k_step,
   input  logic              wr_step,
   output logic [ADDR_W-1:0] rd_a_addr,
   output logic [ADDR_W-1:0] rd_b_addr,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              k_first,
   output logic              k_last,
   output logic              j_last,
   output logic              i_last
);

   logic [DIM_W-1:0]  i_cnt, j_cnt, k_cnt;
   logic [ADDR_W-1:0] a_row, b_row, c_row;

   // a_row = i*K, b_row = k*N, c_row = i*N, all maintained by addition
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         i_cnt <= '0;
         j_cnt <= '0;
         k_cnt <= '0;
         a_row <= '0;
         b_row <= '0;
         c_row <= '0;
      end else if (clear) begin
         i_cnt <= '0;
         j_cnt <= '0;
         k_cnt <= '0;
         a_row <= '0;
         b_row <= '0;
         c_row <= '0;
      end else if (k_step) begin
         k_cnt <= k_cnt + DIM_W'(1);
         b_row <= b_row + ADDR_W'(dim_n);
      end else if (wr_step) begin
         k_cnt <= '0;
         b_row <= '0;
         if (j_last) begin
            j_cnt <= '0;
            i_cnt <= i_cnt + DIM_W'(1);
            a_row <= a_row + ADDR_W'(dim_k);
            c_row <= c_row + ADDR_W'(dim_n);
         end else begin
            j_cnt <= j_cnt + DIM_W'(1);
         end
      end
   end

   assign rd_a_addr = ADDR_W'(A_BASE) + a_row + ADDR_W'(k_cnt);
   assign rd_b_addr = ADDR_W'(B_BASE) + b_row + ADDR_W'(j_cnt);
   assign wr_addr   = ADDR_W'(C_BASE) + c_row + ADDR_W'(j_cnt);

   assign k_first = (k_cnt == '0);
   assign k_last  = (k_cnt == dim_k - DIM_W'(1));
   assign j_last  = (j_cnt == dim_n - DIM_W'(1));
   assign i_last  = (i_cnt == dim_m - DIM_W'(1));

endmodule

// File: rtl/matrix_mult_sequencer.sv
// Control sequencer for the FP32 matrix-multiply engine: fetches A/B operand
// pairs, streams them to an external MAC and writes each C element back.
module matrix_mult_sequencer
   import mm_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 12,
   parameter int DIM_W   = DEF_DIM_W,
   parameter int MAX_DIM = 32,
   parameter int A_BASE  = DEF_A_BASE,
   parameter int B_BASE  = DEF_B_BASE,
   parameter int C_BASE  = DEF_C_BASE
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [4*DIM_W-1:0] cfg,
   output logic               mem_rd_en,
   output logic [ADDR_W-1:0]  mem_rd_addr,
   input  logic [DATA_W-1:0]  mem_rd_data,
   output logic               mem_wr_en,
   output logic [ADDR_W-1:0]  mem_wr_addr,
   output logic [DATA_W-1:0]  mem_wr_data,
   output logic               mac_valid,
   input  logic               mac_ready,
   output logic [DATA_W-1:0]  mac_a,
   output logic [DATA_W-1:0]  mac_b,
   output logic               mac_first,
   output logic               mac_last,
   input  logic               mac_res_valid,
   input  logic [DATA_W-1:0]  mac_res,
   output logic               busy,
   output logic               done,
   output logic               error
);

   localparam int M_LSB  = CFG_ROWS_A * DIM_W;
   localparam int K_LSB  = CFG_COLS_A * DIM_W;
   localparam int K2_LSB = CFG_ROWS_B * DIM_W;
   localparam int N_LSB  = CFG_COLS_B * DIM_W;

   mm_state_e state_q, state_d;

   logic [DIM_W-1:0]  dim_m, dim_k, dim_k2, dim_n;
   logic [DATA_W-1:0] a_reg, b_reg, c_reg;
   logic              done_q, error_q;
   logic              latch_cfg, set_done, set_error;
   logic              ag_clear, k_step, wr_step;
   logic [ADDR_W-1:0] rd_a_addr, rd_b_addr, wr_addr;
   logic              k_first, k_last, j_last, i_last;

   function automatic logic dims_bad(input logic [DIM_W-1:0] m, input logic [DIM_W-1:0] k,
                                     input logic [DIM_W-1:0] k2, input logic [DIM_W-1:0] n);
      dims_bad = (k != k2) || (m == '0) || (k == '0) || (k2 == '0) || (n == '0) ||
                 (int'(m) > MAX_DIM) || (int'(k) > MAX_DIM) ||
                 (int'(k2) > MAX_DIM) || (int'(n) > MAX_DIM);
   endfunction

   mm_addr_gen #(
      .ADDR_W (ADDR_W),
      .DIM_W  (DIM_W),
      .A_BASE (A_BASE),
      .B_BASE (B_BASE),
      .C_BASE (C_BASE)
   ) u_addr_gen (
      .clk       (clk),
      .reset     (reset),
      .dim_m     (dim_m),
      .dim_k     (dim_k),
      .dim_n     (dim_n),
      .clear     (ag_clear),
      .k_step    (k_step),
      .wr_step   (wr_step),
      .rd_a_addr (rd_a_addr),
      .rd_b_addr (rd_b_addr),
      .wr_addr   (wr_addr),
      .k_first   (k_first),
      .k_last    (k_last),
      .j_last    (j_last),
      .i_last    (i_last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      latch_cfg   = 1'b0;
      set_done    = 1'b0;
      set_error   = 1'b0;
      ag_clear    = 1'b0;
      k_step      = 1'b0;
      wr_step     = 1'b0;
      mem_rd_en   = 1'b0;
      mem_rd_addr = '0;
      mem_wr_en   = 1'b0;
      mem_wr_addr = '0;
      mac_valid   = 1'b0;
      mac_first   = 1'b0;
      mac_last    = 1'b0;
      busy        = 1'b0;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               latch_cfg = 1'b1;
               state_d   = CHECK;
            end
         end
         CHECK: begin
            busy = 1'b1;
            if (dims_bad(dim_m, dim_k, dim_k2, dim_n)) begin
               set_done  = 1'b1;
               set_error = 1'b1;
               state_d   = ERR;
            end else begin
               ag_clear = 1'b1;
               state_d  = RD_A;
            end
         end
         RD_A: begin
            busy        = 1'b1;
            mem_rd_en   = 1'b1;
            mem_rd_addr = rd_a_addr;
            state_d     = RD_B;
         end
         RD_B: begin
            busy        = 1'b1;
            mem_rd_en   = 1'b1;
            mem_rd_addr = rd_b_addr;
            state_d     = CAP;
         end
         CAP: begin
            busy    = 1'b1;
            state_d = ISSUE;
         end
         // Operands and k only move on the handshake, so the pair holds while stalled
         ISSUE: begin
            busy      = 1'b1;
            mac_valid = 1'b1;
            mac_first = k_first;
            mac_last  = k_last;
            if (mac_ready) begin
               if (k_last) begin
                  state_d = WAIT_RES;
               end else begin
                  k_step  = 1'b1;
                  state_d = RD_A;
               end
            end
         end
         WAIT_RES: begin
            busy = 1'b1;
            if (mac_res_valid) state_d = WRITE;
         end
         WRITE: begin
            busy        = 1'b1;
            mem_wr_en   = 1'b1;
            mem_wr_addr = wr_addr;
            wr_step     = 1'b1;
            if (i_last && j_last) begin
               set_done = 1'b1;
               state_d  = DONE;
            end else begin
               state_d = RD_A;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dim_m   <= '0;
         dim_k   <= '0;
         dim_k2  <= '0;
         dim_n   <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         c_reg   <= '0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         if (latch_cfg) begin
            dim_m   <= cfg[M_LSB +: DIM_W];
            dim_k   <= cfg[K_LSB +: DIM_W];
            dim_k2  <= cfg[K2_LSB +: DIM_W];
            dim_n   <= cfg[N_LSB +: DIM_W];
            done_q  <= 1'b0;
            error_q <= 1'b0;
         end
         if (state_q == RD_B) a_reg <= mem_rd_data;
         if (state_q == CAP)  b_reg <= mem_rd_data;
         if (state_q == WAIT_RES && mac_res_valid) c_reg <= mac_res;
         if (set_done)  done_q  <= 1'b1;
         if (set_error) error_q <= 1'b1;
      end
   end

   assign mac_a       = a_reg;
   assign mac_b       = b_reg;
   assign mem_wr_data = c_reg;
   assign done        = done_q;
   assign error       = error_q;

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Directed bench for matrix_mult_sequencer with a RAM model and an integer
// multiply-accumulate model standing in for the FP MAC.
module tb_matrix_mult_sequencer;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 12;
   localparam int DIM_W  = 8;
   localparam int A_B    = 2;
   localparam int B_B    = 1026;
   localparam int C_B    = 2050;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [31:0]       cfg = 32'h0;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic              mac_valid;
   logic              mac_ready = 1'b1;
   logic [DATA_W-1:0] mac_a, mac_b;
   logic              mac_first, mac_last;
   logic              mac_res_valid;
   logic [DATA_W-1:0] mac_res;
   logic              busy, done, error;

   matrix_mult_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .cfg           (cfg),
      .mem_rd_en     (mem_rd_en),
      .mem_rd_addr   (mem_rd_addr),
      .mem_rd_data   (mem_rd_data),
      .mem_wr_en     (mem_wr_en),
      .mem_wr_addr   (mem_wr_addr),
      .mem_wr_data   (mem_wr_data),
      .mac_valid     (mac_valid),
      .mac_ready     (mac_ready),
      .mac_a         (mac_a),
      .mac_b         (mac_b),
      .mac_first     (mac_first),
      .mac_last      (mac_last),
      .mac_res_valid (mac_res_valid),
      .mac_res       (mac_res),
      .busy          (busy),
      .done          (done),
      .error         (error)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:4095];

   int checks = 0;
   int errors = 0;

   // Observed activity, owned solely by the monitor process
   int          rd_cnt = 0, hs_cnt = 0, last_cnt = 0, overlap = 0, res_cnt = 0;
   logic [ADDR_W-1:0] rd_log[$];
   logic [ADDR_W-1:0] wr_adr[$];
   logic [31:0]       wr_dat[$];
   logic              rd_pend = 1'b0;
   logic [ADDR_W-1:0] rd_pend_addr = '0;
   logic [31:0]       acc = 0, res_val = 0;

   always @(negedge clk) begin
      if (reset) begin
         mem_rd_data   = 32'h0;
         mac_res_valid = 1'b0;
         mac_res       = 32'h0;
         res_cnt       = 0;
         rd_pend       = 1'b0;
      end else begin
         mem_rd_data  = rd_pend ? mem[rd_pend_addr] : 32'hDEAD_BEEF;
         rd_pend      = mem_rd_en;
         rd_pend_addr = mem_rd_addr;
         if (mem_rd_en) begin
            rd_cnt++;
            rd_log.push_back(mem_rd_addr);
         end
         if (mem_wr_en) begin
            wr_adr.push_back(mem_wr_addr);
            wr_dat.push_back(mem_wr_data);
         end
         if (mem_rd_en && mem_wr_en) overlap++;
         mac_res_valid = 1'b0;
         mac_res       = $urandom;
         if (res_cnt != 0) begin
            res_cnt--;
            if (res_cnt == 0) begin
               mac_res_valid = 1'b1;
               mac_res       = res_val;
            end
         end
         if (mac_valid && mac_ready) begin
            hs_cnt++;
            acc = mac_first ? (mac_a * mac_b) : (acc + mac_a * mac_b);
            if (mac_last) begin
               last_cnt++;
               res_val = acc;
               res_cnt = 2;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic pulse_start(input logic [31:0] c);
      @(posedge clk);
      #1 cfg = c;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      while (cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_c(input int base, input int m, input int k, input int n, input string tag);
      logic [31:0] exp;
      for (int idx = 0; idx < m * n && base + idx < wr_adr.size(); idx++) begin
         exp = 0;
         for (int kk = 0; kk < k; kk++)
            exp = exp + mem[A_B + (idx / n) * k + kk] * mem[B_B + kk * n + (idx % n)];
         chk({tag, "_caddr"}, 128'(wr_adr[base + idx]), 128'(C_B + idx));
         chk({tag, "_cdata"}, 128'(wr_dat[base + idx]), 128'(exp));
      end
   endtask

   typedef struct {
      logic [31:0] cfg;
      bit          err;
      int          reads;
      int          writes;
      int          hs;
   } vec_t;

   vec_t tbl [9];

   initial begin #800000; $display("FAIL watchdog"); $fatal(1, "watchdog"); end

   initial begin
      int cyc, rb, wb, hb, ob, lb, rl;
      bit ok;
      int exp_rd [6];
      logic [31:0] cap_a, cap_b;
      logic        cap_f, cap_l;

      tbl[0] = '{32'h01010101, 1'b0,   2,  1,  1};
      tbl[1] = '{32'h02030302, 1'b0,  24,  4, 12};
      tbl[2] = '{32'h04040404, 1'b0, 128, 16, 64};
      tbl[3] = '{32'h04040304, 1'b1,   0,  0,  0};
      tbl[4] = '{32'h21040404, 1'b1,   0,  0,  0};
      tbl[5] = '{32'h00010101, 1'b1,   0,  0,  0};
      tbl[6] = '{32'h03020205, 1'b0,  60, 15, 30};
      tbl[7] = '{32'h01202001, 1'b0,  64,  1, 32};
      tbl[8] = '{32'h02010103, 1'b0,  12,  6,  6};
      exp_rd = '{2, 1026, 3, 1028, 4, 1030};

      for (int a = 0; a < 4096; a++) mem[a] = $urandom_range(1, 1000);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ctl", 128'({mem_rd_en, mem_wr_en, mac_valid, mac_first, mac_last, busy, done, error}), 128'(0));
      chk("reset_data", {mem_rd_addr, mem_wr_addr, mem_wr_data, mac_a, mac_b}, 128'(0));
      @(posedge clk);
      #1 reset = 1'b0;

      for (int t = 0; t < 9; t++) begin
         rb = rd_cnt; wb = wr_adr.size(); hb = hs_cnt; ob = overlap;
         pulse_start(tbl[t].cfg);
         wait_done(2000, cyc, ok);
         chk("done_seen", 128'(ok), 128'(1));
         @(posedge clk);
         #1;
         chk("error_flag", 128'(error), 128'(tbl[t].err));
         chk("busy_low", 128'(busy), 128'(0));
         chk("read_count", 128'(rd_cnt - rb), 128'(tbl[t].reads));
         chk("write_count", 128'(wr_adr.size() - wb), 128'(tbl[t].writes));
         chk("mac_handshakes", 128'(hs_cnt - hb), 128'(tbl[t].hs));
         chk("rd_wr_overlap", 128'(overlap - ob), 128'(0));
         if (tbl[t].err)
            chk("err_latency_le2", 128'(cyc <= 2), 128'(1));
         else
            check_c(wb, int'(tbl[t].cfg[31:24]), int'(tbl[t].cfg[23:16]), int'(tbl[t].cfg[7:0]), "vec");
      end

      // start pulsed mid-run with a different cfg must be ignored
      wb = wr_adr.size(); rl = rd_log.size();
      pulse_start(32'h02030302);
      repeat (8) @(posedge clk);
      #1 cfg = 32'h01010101;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(2000, cyc, ok);
      chk("midstart_done", 128'(ok), 128'(1));
      @(posedge clk);
      #1;
      chk("midstart_writes", 128'(wr_adr.size() - wb), 128'(4));
      for (int r = 0; r < 6; r++)
         chk("read_order", 128'(rd_log[rl + r]), 128'(exp_rd[r]));
      check_c(wb, 2, 3, 2, "midstart");

      // MAC back-pressure: pair must hold for the whole stall
      mac_ready = 1'b0;
      wb = wr_adr.size();
      pulse_start(32'h02020202);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (mac_valid) ok = 1'b1;
      end
      chk("stall_valid_seen", 128'(ok), 128'(1));
      cap_a = mac_a; cap_b = mac_b; cap_f = mac_first; cap_l = mac_last;
      chk("stall_pair", {cap_a, cap_b, cap_f, cap_l}, {mem[A_B], mem[B_B], 1'b1, 1'b0});
      hb = hs_cnt;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("stall_stable", {mac_valid, mac_a, mac_b, mac_first, mac_last}, {1'b1, cap_a, cap_b, cap_f, cap_l});
      end
      chk("stall_no_accept", 128'(hs_cnt - hb), 128'(0));
      @(posedge clk);
      #1 mac_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("stall_one_accept", 128'(hs_cnt - hb), 128'(1));
      chk("stall_valid_drop", 128'(mac_valid), 128'(0));
      wait_done(2000, cyc, ok);
      chk("stall_done", 128'(ok), 128'(1));
      @(posedge clk);
      #1;
      chk("stall_writes", 128'(wr_adr.size() - wb), 128'(4));
      check_c(wb, 2, 2, 2, "stall");

      // reset during WAIT_RES: immediate quiet outputs, no write, clean restart
      lb = last_cnt;
      pulse_start(32'h02020202);
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(posedge clk);
         if (last_cnt > lb) ok = 1'b1;
      end
      chk("waitres_reached", 128'(ok), 128'(1));
      #1;
      chk("waitres_busy", 128'(busy), 128'(1));
      wb = wr_adr.size();
      reset = 1'b1;
      #1;
      chk("midreset_ctl", 128'({mem_rd_en, mem_wr_en, mac_valid, mac_first, mac_last, busy, done, error}), 128'(0));
      chk("midreset_data", {mem_rd_addr, mem_wr_addr, mem_wr_data, mac_a, mac_b}, 128'(0));
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      chk("midreset_no_write", 128'(wr_adr.size() - wb), 128'(0));
      wb = wr_adr.size();
      pulse_start(32'h02020202);
      wait_done(2000, cyc, ok);
      chk("restart_done", 128'(ok), 128'(1));
      @(posedge clk);
      #1;
      chk("restart_error", 128'(error), 128'(0));
      chk("restart_writes", 128'(wr_adr.size() - wb), 128'(4));
      check_c(wb, 2, 2, 2, "restart");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
